// File: rtl/stopwatch_counter.sv
// BCD stopwatch core: counts MM:SS.hh on a divided tick, driven by a start/stop/lap/clear FSM,
// with display registers that can be frozen for lap readout.
module stopwatch_counter #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [2:0] disp_min_t,
    output logic [3:0] disp_min_u,
    output logic [2:0] disp_sec_t,
    output logic [3:0] disp_sec_u,
    output logic [3:0] disp_hun_t,
    output logic [3:0] disp_hun_u,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    // Digit 0 is hundredths units, digit 5 is minutes tens.
    localparam logic [5:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

    state_t          state_reg, state_next;
    logic [7:0]      presc_reg, presc_next;
    logic [5:0][3:0] cnt_reg, cnt_next, inc_cnt;
    logic [6:0]      carry;
    logic            overflow_reg, overflow_next;
    logic            running_reg, lap_reg;
    logic [2:0]      disp_min_t_reg, disp_sec_t_reg;
    logic [3:0]      disp_min_u_reg, disp_sec_u_reg, disp_hun_t_reg, disp_hun_u_reg;
    logic            counting, clear_ok, adv, disp_load;

    assign counting = (state_reg == RUN) || (state_reg == LAP);
    assign clear_ok = clear && ((state_reg == IDLE) || (state_reg == PAUSE));
    assign adv      = counting && tick && (presc_reg == PRESC_LAST);

    // clear beats start_stop beats lap; clear is only accepted in IDLE/PAUSE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (clear) state_next = IDLE;
                     else if (start_stop) state_next = RUN;
            RUN:     if (start_stop) state_next = PAUSE;
                     else if (lap) state_next = LAP;
            LAP:     if (start_stop) state_next = PAUSE;
                     else if (lap) state_next = RUN;
            PAUSE:   if (clear) state_next = IDLE;
                     else if (start_stop) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        presc_next = presc_reg;
        if (clear_ok || ((state_reg == IDLE) && (state_next == RUN)))
            presc_next = 8'd0;
        else if (counting && tick)
            presc_next = (presc_reg == PRESC_LAST) ? 8'd0 : presc_reg + 8'd1;
    end

    always_comb begin
        carry    = '0;
        carry[0] = adv;
        for (int i = 0; i < 6; i++)
            carry[i+1] = carry[i] && (cnt_reg[i] == DIG_MAX[i]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign inc_cnt[gi] = !carry[gi] ? cnt_reg[gi] :
                                 (cnt_reg[gi] == DIG_MAX[gi]) ? 4'd0 : cnt_reg[gi] + 4'd1;
        end
    endgenerate

    assign cnt_next      = clear_ok ? '0 : inc_cnt;
    assign overflow_next = clear_ok ? 1'b0 : (overflow_reg || carry[6]);
    // The display freezes only while we stay in LAP; entering or leaving LAP loads live.
    assign disp_load     = !((state_reg == LAP) && (state_next == LAP));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            presc_reg      <= 8'd0;
            cnt_reg        <= '0;
            overflow_reg   <= 1'b0;
            running_reg    <= 1'b0;
            lap_reg        <= 1'b0;
            disp_min_t_reg <= 3'd0;
            disp_min_u_reg <= 4'd0;
            disp_sec_t_reg <= 3'd0;
            disp_sec_u_reg <= 4'd0;
            disp_hun_t_reg <= 4'd0;
            disp_hun_u_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            cnt_reg      <= cnt_next;
            overflow_reg <= overflow_next;
            running_reg  <= (state_next == RUN) || (state_next == LAP);
            lap_reg      <= (state_next == LAP);
            if (disp_load) begin
                disp_min_t_reg <= cnt_next[5][2:0];
                disp_min_u_reg <= cnt_next[4];
                disp_sec_t_reg <= cnt_next[3][2:0];
                disp_sec_u_reg <= cnt_next[2];
                disp_hun_t_reg <= cnt_next[1];
                disp_hun_u_reg <= cnt_next[0];
            end
        end
    end

    assign disp_min_t = disp_min_t_reg;
    assign disp_min_u = disp_min_u_reg;
    assign disp_sec_t = disp_sec_t_reg;
    assign disp_sec_u = disp_sec_u_reg;
    assign disp_hun_t = disp_hun_t_reg;
    assign disp_hun_u = disp_hun_u_reg;
    assign running    = running_reg;
    assign lap_active = lap_reg;
    assign overflow   = overflow_reg;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: one instance with TICK_DIV=1, one with TICK_DIV=4,
// sharing all inputs; display compared as a 24-bit MMSShh BCD word.
module tb_stopwatch_counter;
    logic clk = 1'b0;
    logic reset = 1'b0, tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;

    logic [2:0] a_min_t, a_sec_t, b_min_t, b_sec_t;
    logic [3:0] a_min_u, a_sec_u, a_hun_t, a_hun_u;
    logic [3:0] b_min_u, b_sec_u, b_hun_t, b_hun_u;
    logic       a_run, a_lap, a_ovf, b_run, b_lap, b_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_counter #(.TICK_DIV(1)) u1 (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
        .disp_min_t(a_min_t), .disp_min_u(a_min_u), .disp_sec_t(a_sec_t), .disp_sec_u(a_sec_u),
        .disp_hun_t(a_hun_t), .disp_hun_u(a_hun_u),
        .running(a_run), .lap_active(a_lap), .overflow(a_ovf)
    );

    stopwatch_counter #(.TICK_DIV(4)) u4 (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
        .disp_min_t(b_min_t), .disp_min_u(b_min_u), .disp_sec_t(b_sec_t), .disp_sec_u(b_sec_u),
        .disp_hun_t(b_hun_t), .disp_hun_u(b_hun_u),
        .running(b_run), .lap_active(b_lap), .overflow(b_ovf)
    );

    wire [23:0] disp_a = {1'b0, a_min_t, a_min_u, 1'b0, a_sec_t, a_sec_u, a_hun_t, a_hun_u};
    wire [23:0] disp_b = {1'b0, b_min_t, b_min_u, 1'b0, b_sec_t, b_sec_u, b_hun_t, b_hun_u};

    function automatic logic [23:0] t(input int m, input int s, input int h);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
        $display("check %0d %s observed %h expected %h", checks, tag, obs, exp);
    endtask

    task automatic step(input logic tk, input logic ss, input logic lp, input logic cl);
        tick = tk; start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_disp", disp_a, t(0, 0, 0));
        chk("reset_running", 24'(a_run), 24'd0);
        chk("reset_lap", 24'(a_lap), 24'd0);
        chk("reset_ovf", 24'(a_ovf), 24'd0);

        // Basic count: 150 ticks; TICK_DIV=4 instance sees 37 advances.
        step(0, 1, 0, 0);
        chk("start_running", 24'(a_run), 24'd1);
        ticks(150);
        chk("count150_disp", disp_a, t(0, 1, 50));
        chk("count150_running", 24'(a_run), 24'd1);
        chk("count150_ovf", 24'(a_ovf), 24'd0);
        chk("div4_150_disp", disp_b, t(0, 0, 37));
        step(0, 1, 0, 0);
        chk("pause_running", 24'(a_run), 24'd0);
        chk("pause_disp", disp_a, t(0, 1, 50));
        step(0, 0, 0, 1);
        chk("clear_disp", disp_a, t(0, 0, 0));

        // Wrap: preload 59:59.99 while paused, then one tick.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        force u1.cnt_reg = 24'h595999;
        @(posedge clk);
        #1 release u1.cnt_reg;
        chk("preload_disp", disp_a, t(59, 59, 99));
        step(0, 1, 0, 0);
        chk("preload_run_disp", disp_a, t(59, 59, 99));
        step(1, 0, 0, 0);
        chk("wrap_disp", disp_a, t(0, 0, 0));
        chk("wrap_ovf", 24'(a_ovf), 24'd1);
        chk("wrap_running", 24'(a_run), 24'd1);
        ticks(5);
        chk("after_wrap_disp", disp_a, t(0, 0, 5));
        chk("ovf_sticky", 24'(a_ovf), 24'd1);
        step(0, 1, 0, 0);
        chk("ovf_paused", 24'(a_ovf), 24'd1);
        step(0, 0, 0, 1);
        chk("ovf_clear_disp", disp_a, t(0, 0, 0));
        chk("ovf_clear_ovf", 24'(a_ovf), 24'd0);
        chk("ovf_clear_running", 24'(a_run), 24'd0);

        // Lap freeze and release.
        step(0, 1, 0, 0);
        ticks(500);
        chk("lap_pre_disp", disp_a, t(0, 5, 0));
        step(0, 0, 1, 0);
        chk("lap_active", 24'(a_lap), 24'd1);
        ticks(300);
        chk("lap_frozen_disp", disp_a, t(0, 5, 0));
        chk("lap_running", 24'(a_run), 24'd1);
        step(0, 0, 1, 0);
        chk("lap_release_disp", disp_a, t(0, 8, 0));
        chk("lap_release_flag", 24'(a_lap), 24'd0);
        step(1, 0, 1, 0);
        chk("lap_capture_incr", disp_a, t(0, 8, 1));
        ticks(10);
        chk("lap2_frozen", disp_a, t(0, 8, 1));
        step(0, 1, 0, 0);
        chk("lap_to_pause_disp", disp_a, t(0, 8, 11));
        chk("lap_to_pause_lap", 24'(a_lap), 24'd0);
        chk("lap_to_pause_run", 24'(a_run), 24'd0);

        // Stop with a coincident tick: the tick still counts.
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(200);
        chk("stop_pre_disp", disp_a, t(0, 2, 0));
        step(1, 1, 0, 0);
        chk("stop_tick_disp", disp_a, t(0, 2, 1));
        chk("stop_tick_running", 24'(a_run), 24'd0);
        ticks(50);
        chk("stopped_hold", disp_a, t(0, 2, 1));
        step(0, 0, 0, 1);
        chk("stop_clear_disp", disp_a, t(0, 0, 0));

        // Coincident pulses and ignored controls.
        step(0, 1, 0, 0);
        ticks(7);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("ss_lap_running", 24'(a_run), 24'd1);
        chk("ss_lap_lapflag", 24'(a_lap), 24'd0);
        chk("ss_lap_disp", disp_a, t(0, 0, 7));
        step(0, 0, 0, 1);
        chk("clear_in_run_running", 24'(a_run), 24'd1);
        chk("clear_in_run_disp", disp_a, t(0, 0, 7));
        step(1, 0, 0, 1);
        chk("clear_tick_in_run", disp_a, t(0, 0, 8));
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("lap_in_pause", 24'(a_lap), 24'd0);
        step(0, 0, 0, 1);
        chk("pause_clear_disp", disp_a, t(0, 0, 0));
        step(0, 1, 0, 1);
        chk("idle_clear_beats_ss", 24'(a_run), 24'd0);
        step(0, 0, 1, 0);
        chk("lap_in_idle", 24'(a_lap), 24'd0);

        // TICK_DIV=4 and synchronous reset mid-run.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("div4_reset_disp", disp_b, t(0, 0, 0));
        step(0, 1, 0, 0);
        ticks(40);
        chk("div4_40_disp", disp_b, t(0, 0, 10));
        chk("div1_40_disp", disp_a, t(0, 0, 40));
        reset = 1'b1; tick = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; tick = 1'b0;
        chk("midrun_reset_disp_a", disp_a, t(0, 0, 0));
        chk("midrun_reset_disp_b", disp_b, t(0, 0, 0));
        chk("midrun_reset_running", 24'({a_run, b_run}), 24'd0);
        chk("midrun_reset_lap_ovf", 24'({a_lap, a_ovf, b_lap, b_ovf}), 24'd0);
        ticks(3);
        chk("idle_after_reset", disp_a, t(0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
